shift_sub_divider: RTL
======================

Name: shift_sub_divider

Overview:
- Sequential unsigned restoring divider: shift/subtract counterpart to the team's shift/add multiplier.
- Contains a one-hot Moore controller plus its datapath: partial-remainder register A, dividend/quotient register Q, divisor register M, and an iteration counter.
- Accepts one division per Go request. Produces Quotient/Remainder with a one-cycle Done pulse.
- Sits beside the multiplier in the arithmetic lab datapath and uses the same Go/Busy/Done style.

Parameters:
N, 8, operand width in bits for dividend, divisor, quotient and remainder (N >= 2).

Ports:
Clock  in  1  system clock; all state changes on the rising edge.
Reset  in  1  asynchronous, active-high; forces IdleS and clears all registers.
Go  in  1  start request; sampled only in IdleS.
Dividend  in  N  unsigned dividend; captured in LoadS only.
Divisor  in  N  unsigned divisor; captured in LoadS only.
Busy  out  1  1 in LoadS, ShiftS and SubS; else 0.
Done  out  1  1 for exactly one cycle, in DoneS.
Quotient  out  N  registered result; updated only on entry to DoneS.
Remainder  out  N  registered result; updated only on entry to DoneS.
DivByZero  out  1  registered flag; updated on entry to DoneS (1 if captured divisor was 0, else 0).

Behaviour:
- Reset (asynchronous, active-high, any state, including mid-operation):
  - state=IdleS; A, Q, M, counter = 0.
  - Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0.
  - Any operation in progress is abandoned.
- State machine: one-hot, 5 states (IdleS, LoadS, ShiftS, SubS, DoneS); Moore outputs.
- IdleS:
  - Go=1 -> LoadS; else stay.
  - Quotient, Remainder and DivByZero hold their last values.
- LoadS:
  - A<=0 (N+1 bits), Q<=Dividend, M<=Divisor, counter<=N.
  - If Divisor==0 -> DoneS, with Quotient<={N{1}}, Remainder<=Dividend, DivByZero<=1.
  - Else -> ShiftS.
- ShiftS: {A,Q} <= {A,Q}<<1 (Q[0] becomes 0) -> SubS.
- SubS:
  - Compute D = A - {1'b0,M} at N+1 bits.
  - If D[N]==1 (negative): A unchanged (restore), Q[0]<=0.
  - Else: A<=D, Q[0]<=1.
  - counter<=counter-1.
  - If counter==1 (last iteration) -> DoneS, loading Quotient<=final Q and Remainder<=final A[N-1:0] (including this cycle's update) and DivByZero<=0.
  - Else -> ShiftS.
- DoneS: Done=1 for this cycle only; -> IdleS unconditionally. Go in DoneS is ignored.
- Latency, counted from the Clock edge that samples Go=1 in IdleS (edge 0):
  - Normal division: Done is high in cycle 2N+2 (18 for N=8); result outputs are valid from that cycle on.
  - Divide-by-zero: Done is high in cycle 2.
- Back-to-back: earliest next Go sample is the first IdleS cycle after DoneS, giving a throughput of one division per 2N+3 cycles.
- Go while Busy=1 is ignored. Operand changes after LoadS have no effect.
- Arithmetic:
  - A is N+1 bits wide so the subtract sign is unambiguous for every divisor up to 2^N-1.
  - Counter width is clog2(N+1). The counter never wraps; the exit is decided on counter==1.
- Invariant: for divisor != 0, Quotient*Divisor + Remainder == Dividend and Remainder < Divisor.

Test Plan:
- N=8, Go with 100/7 -> Done only in cycle 18; Quotient=14, Remainder=2, DivByZero=0; Busy=1 in cycles 1-17.
- 5/9 -> Quotient=0, Remainder=5. 255/1 -> Quotient=255, Remainder=0. 255/255 -> Quotient=1, Remainder=0.
- 77/0 -> Done in cycle 2; Quotient=255, Remainder=77, DivByZero=1. A following 12/4 -> Quotient=3, Remainder=0, DivByZero=0.
- Start 200/3, then pulse Go high and change Dividend/Divisor during cycles 3-10 -> result still Quotient=66, Remainder=2 at cycle 18; exactly one Done pulse.
- Start 200/3, assert Reset at cycle 9 -> outputs immediately 0, state IdleS. After release, 50/6 -> Quotient=8, Remainder=2 at 18 cycles after its Go.
- Random sweep of 1000 operand pairs, including Divisor=1, Divisor>Dividend and max values -> invariant holds; Done width is exactly 1 cycle.

Source files
------------

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider: one-hot Moore controller driving a
// shift/subtract datapath (A = partial remainder, Q = dividend/quotient, M = divisor).
module shift_sub_divider #(
    parameter int N = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Go,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         DivByZero
);

    localparam int CW = $clog2(N + 1);

    localparam logic [4:0] IdleS  = 5'b00001;
    localparam logic [4:0] LoadS  = 5'b00010;
    localparam logic [4:0] ShiftS = 5'b00100;
    localparam logic [4:0] SubS   = 5'b01000;
    localparam logic [4:0] DoneS  = 5'b10000;

    logic [4:0]    state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic [N:0]    diff;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        // A carries one extra bit so diff[N] is a reliable borrow for any divisor.
        diff    = a_q - {1'b0, m_q};

        case (state_q)
            IdleS: begin
                if (Go) begin
                    state_d = LoadS;
                end
            end
            LoadS: begin
                a_d   = '0;
                q_d   = Dividend;
                m_d   = Divisor;
                cnt_d = CW'(N);
                if (Divisor == '0) begin
                    state_d = DoneS;
                    quot_d  = '1;
                    rem_d   = Dividend;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = ShiftS;
                end
            end
            ShiftS: begin
                {a_d, q_d} = {a_q, q_q} << 1;
                state_d    = SubS;
            end
            SubS: begin
                if (diff[N]) begin
                    q_d[0] = 1'b0;
                end else begin
                    a_d    = diff;
                    q_d[0] = 1'b1;
                end
                cnt_d = cnt_q - CW'(1);
                // Results are captured from this cycle's update, not the stale registers.
                if (cnt_q == CW'(1)) begin
                    state_d = DoneS;
                    quot_d  = q_d;
                    rem_d   = a_d[N-1:0];
                    dbz_d   = 1'b0;
                end else begin
                    state_d = ShiftS;
                end
            end
            DoneS: begin
                state_d = IdleS;
            end
            default: begin
                state_d = IdleS;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IdleS;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Busy      = (state_q == LoadS) || (state_q == ShiftS) || (state_q == SubS);
    assign Done      = (state_q == DoneS);
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivByZero = dbz_q;

endmodule
